// File: rtl/tcdm_sram_port_ctrl.sv
// tcdm_sram_port_ctrl: TCDM request port to SRAM macro controller with range check and 2-entry response FIFO
module tcdm_sram_port_ctrl #(
  parameter int unsigned AS_W      = 1,
  parameter int unsigned AW_W      = 6,
  parameter int unsigned AC_W      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
  parameter logic [31:0] ERR_DATA  = 32'h0BAD_ACCE
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [31:0]     addr_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [31:0]     wdata_i,
  output logic            r_valid_o,
  input  logic            r_ready_i,
  output logic [31:0]     r_rdata_o,
  output logic            r_err_o,
  output logic            mem_cen_o,
  output logic            mem_rdwen_o,
  output logic [AS_W-1:0] mem_as_o,
  output logic [AW_W-1:0] mem_aw_o,
  output logic [AC_W-1:0] mem_ac_o,
  output logic [31:0]     mem_d_o,
  output logic [31:0]     mem_bw_o,
  input  logic [31:0]     mem_q_i
);
  localparam int unsigned WA = AS_W + AW_W + AC_W;
  localparam logic [31:0] HI_MASK = ~((32'd1 << (WA + 2)) - 32'd1);
  logic [WA-1:0] waddr;
  logic          in_range, pop, push, inflight, p_we, p_err, wi;
  logic [1:0]    count;
  logic [2:0]    occ;
  logic [32:0]   fifo [2];
  logic [32:0]   push_data;
  assign waddr     = addr_i[WA+1:2];
  assign in_range  = (addr_i & HI_MASK) == (BASE_ADDR & HI_MASK);
  assign pop       = r_valid_o & r_ready_i;
  assign occ       = {1'b0, count} + {2'b0, inflight};
  // Credit counts the access in the macro pipeline so a push always finds room.
  assign gnt_o     = rst_ni & req_i & (occ < 3'd2 + {2'b0, pop});
  assign push      = inflight;
  assign push_data = {p_err, p_err ? ERR_DATA : (p_we ? 32'd0 : mem_q_i)};
  assign wi        = count[1] | (count[0] & ~pop);
  assign mem_cen_o   = ~(gnt_o & in_range);
  assign mem_rdwen_o = ~we_i;
  assign mem_as_o    = waddr[AC_W+AW_W +: AS_W];
  assign mem_aw_o    = waddr[AC_W +: AW_W];
  assign mem_ac_o    = waddr[0 +: AC_W];
  assign mem_d_o     = wdata_i;
  for (genvar k = 0; k < 4; k++) begin : g_bw
    assign mem_bw_o[8*k +: 8] = {8{be_i[k] & we_i}};
  end
  assign r_valid_o = count != 2'd0;
  assign r_rdata_o = fifo[0][31:0];
  assign r_err_o   = fifo[0][32];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= 1'b0;
      p_we     <= 1'b0;
      p_err    <= 1'b0;
      count    <= 2'd0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      inflight <= gnt_o;
      if (gnt_o) begin
        p_we  <= we_i;
        p_err <= ~in_range;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) fifo[0] <= fifo[1];
      if (push) fifo[wi] <= push_data;
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && count == 2'd2 && !pop));
endmodule
